cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_logic.sv | 114 +++++++++++
 tb/tb_cond_logic.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the condition field against the
// stored NZCV flags, gates the decoder's write requests, maintains the
// architectural flags and counts executed versus squashed instructions.
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             cond_pass;
    logic             issue;
    logic             exec_now;
    logic [1:0]       flag_we;
    logic [CNT_W-1:0] exec_cnt_reg;
    logic [CNT_W-1:0] skip_cnt_reg;
    logic [CNT_W-1:0] exec_cnt_next;
    logic [CNT_W-1:0] skip_cnt_next;

    // Condition evaluation uses only the stored flags, so a flag write is
    // seen by the following instruction and never bypassed.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = Flags[2];
            4'b0001: cond_pass = ~Flags[2];
            4'b0010: cond_pass = Flags[1];
            4'b0011: cond_pass = ~Flags[1];
            4'b0100: cond_pass = Flags[3];
            4'b0101: cond_pass = ~Flags[3];
            4'b0110: cond_pass = Flags[0];
            4'b0111: cond_pass = ~Flags[0];
            4'b1000: cond_pass = Flags[1] & ~Flags[2];
            4'b1001: cond_pass = ~Flags[1] | Flags[2];
            4'b1010: cond_pass = (Flags[3] == Flags[0]);
            4'b1011: cond_pass = (Flags[3] != Flags[0]);
            4'b1100: cond_pass = ~Flags[2] & (Flags[3] == Flags[0]);
            4'b1101: cond_pass = Flags[2] | (Flags[3] != Flags[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign issue    = Valid;
    assign exec_now = Valid & cond_pass;
    assign CondEx   = cond_pass;
    assign PCSrc    = PCS  & exec_now;
    assign RegWrite = RegW & exec_now;
    assign MemWrite = MemW & exec_now;

    // Half 1 is {N,Z}, half 0 is {C,V}; each has its own write enable.
    assign flag_we = FlagW & {2{exec_now}};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
            logic [1:0] half_reg;

            // Each flag half loads from the ALU only when its enable is set.
            always_ff @(posedge clk) begin
                if (reset) begin
                    half_reg <= 2'b00;
                end else if (flag_we[gi]) begin
                    half_reg <= ALUFlags[2*gi +: 2];
                end
            end

            assign Flags[2*gi +: 2] = half_reg;
        end
    endgenerate

    // Saturating increments: exactly one counter advances per valid slot.
    always_comb begin
        exec_cnt_next = exec_cnt_reg;
        skip_cnt_next = skip_cnt_reg;
        if (issue) begin
            if (cond_pass) begin
                if (exec_cnt_reg != CNT_MAX) exec_cnt_next = exec_cnt_reg + 1'b1;
            end else begin
                if (skip_cnt_reg != CNT_MAX) skip_cnt_next = skip_cnt_reg + 1'b1;
            end
        end
    end

    // Counter registers; reset overrides any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt_reg <= '0;
            skip_cnt_reg <= '0;
        end else begin
            exec_cnt_reg <= exec_cnt_next;
            skip_cnt_reg <= skip_cnt_next;
        end
    end

    assign ExecCount = exec_cnt_reg;
    assign SkipCount = skip_cnt_reg;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic (CNT_W=4 so saturation is reachable).
module tb_cond_logic;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, Valid, PCS, RegW, MemW;
    logic [3:0]   Cond, ALUFlags;
    logic [1:0]   FlagW;
    logic         PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]   Flags;
    logic [W-1:0] ExecCount, SkipCount;

    cond_logic #(.CNT_W(W)) dut (
        .clk(clk), .reset(reset), .Valid(Valid), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
        .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic         ce, pc, rw, mw;
        logic [3:0]   flags;
        logic [W-1:0] exec, skip;
    } exp_t;

    exp_t sb[$];

    int tests_run = 0;
    int tests_failed = 0;

    // reference state
    logic [3:0]   m_flags;
    logic [W-1:0] m_exec, m_skip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs,
                        input logic regw, input logic memw);
        exp_t e;
        exp_t got;
        logic ce;
        @(negedge clk);
        reset = rst; Valid = v; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = regw; MemW = memw;
        ce = cond_eval(c, m_flags);
        e.tag = tag;
        e.ce = ce;
        e.pc = pcs & ce & v;
        e.rw = regw & ce & v;
        e.mw = memw & ce & v;
        if (rst) begin
            m_flags = 4'h0; m_exec = '0; m_skip = '0;
        end else if (v) begin
            if (ce) begin
                if (fw[1]) m_flags[3:2] = alu[3:2];
                if (fw[0]) m_flags[1:0] = alu[1:0];
                if (m_exec != '1) m_exec = m_exec + 1'b1;
            end else begin
                if (m_skip != '1) m_skip = m_skip + 1'b1;
            end
        end
        e.flags = m_flags; e.exec = m_exec; e.skip = m_skip;
        sb.push_back(e);
        #2;
        got.ce = CondEx; got.pc = PCSrc; got.rw = RegWrite; got.mw = MemWrite;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            $display("[TB] %s cond=%h v=%b rst=%b condex=%b flags=%h exec=%0d skip=%0d",
                     e.tag, c, v, rst, got.ce, Flags, ExecCount, SkipCount);
            check({e.tag, ".condex"},   32'(got.ce), 32'(e.ce));
            check({e.tag, ".pcsrc"},    32'(got.pc), 32'(e.pc));
            check({e.tag, ".regwrite"}, 32'(got.rw), 32'(e.rw));
            check({e.tag, ".memwrite"}, 32'(got.mw), 32'(e.mw));
            check({e.tag, ".flags"},    32'(Flags), 32'(e.flags));
            check({e.tag, ".exec"},     32'(ExecCount), 32'(e.exec));
            check({e.tag, ".skip"},     32'(SkipCount), 32'(e.skip));
        end
    endtask

    initial begin
        reset = 1'b1; Valid = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        m_flags = 4'h0; m_exec = '0; m_skip = '0;
        repeat (2) @(posedge clk);

        // reset state and EQ with Z=0 squashed
        step("rst",      1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
        step("eq_fail",  0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0);
        // AL sets Z, then EQ passes
        step("rst2",     1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
        step("al_setz",  0, 1, 4'hE, 4'h4, 2'b11, 0, 0, 0);
        step("eq_pass",  0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0);
        // partial flag write keeps C,V
        step("al_1111",  0, 1, 4'hE, 4'hF, 2'b11, 1, 0, 0);
        step("nz_only",  0, 1, 4'hE, 4'h0, 2'b10, 0, 0, 0);
        step("cv_only",  0, 1, 4'hE, 4'hC, 2'b01, 0, 0, 0);
        // flags = 1000, LT passes, GE fails
        step("set_n",    0, 1, 4'hE, 4'h8, 2'b11, 0, 0, 0);
        step("lt",       0, 1, 4'hB, 4'h0, 2'b00, 0, 0, 1);
        step("ge",       0, 1, 4'hA, 4'h0, 2'b00, 0, 0, 1);
        // failed flag-setting instruction must not touch flags
        step("fail_fw",  0, 1, 4'h0, 4'hF, 2'b11, 1, 1, 1);
        // bubble: no state change, outputs gated off
        step("bubble",   0, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1);
        // NV is always squashed
        step("nv",       0, 1, 4'hF, 4'h0, 2'b11, 1, 1, 1);
        // skip saturation at 15
        step("rst3",     1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 17; i++) step("sat", 0, 1, 4'hF, 4'h0, 2'b00, 0, 1, 0);
        // reset wins over a same-cycle update; outputs still gated from stored flags
        step("al_ff",    0, 1, 4'hE, 4'hF, 2'b11, 0, 0, 0);
        step("rst_pri",  1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1);
        step("rst_eq",   1, 1, 4'h0, 4'h0, 2'b11, 0, 1, 0);
        // random mix across all condition codes
        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 4) != 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
